// File: rtl/pattern_frame_checker_if.sv
// Ethernet header plus 8-bit payload stream as delivered by eth_axis_rx.
// The master drives the frame and the slave (the checker) returns the ready signals.
interface pattern_frame_checker_if;
  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_eth_payload_axis_tdata;
  logic        s_eth_payload_axis_tvalid;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast;
  logic        s_eth_payload_axis_tuser;

  modport master (
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
           s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
           s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready
  );

  modport slave (
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
           s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
           s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    output s_eth_hdr_ready, s_eth_payload_axis_tready
  );
endinterface

// File: rtl/pattern_frame_checker.sv
// Receive-side checker for looped-back test-pattern frames: validates the header, index and
// payload pattern, measures round-trip latency and keeps saturating statistics.
module pattern_frame_checker #(
  parameter int unsigned DATA_LENGTH = 256,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [15:0] ETH_TYPE    = 16'h88b6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [47:0]            local_mac,
  input  logic [47:0]            peer_mac,
  input  logic [15:0]            timestamp,
  pattern_frame_checker_if.slave eth,
  output logic                   result_valid,
  output logic                   result_ok,
  output logic [15:0]            result_index,
  output logic [15:0]            result_latency,
  output logic [31:0]            good_count,
  output logic [31:0]            hdr_err_count,
  output logic [31:0]            seq_err_count,
  output logic [31:0]            data_err_count,
  output logic [15:0]            max_latency
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PAYLOAD   = 3'd1,
    ST_DROP      = 3'd2,
    ST_DROP_LONG = 3'd3,
    ST_REPORT    = 3'd4
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(DATA_LENGTH - 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  state_t                  state_r, state_nx_s;
  logic [15:0]             byte_cnt_r, byte_cnt_nx_s;
  logic [15:0]             idx_r, idx_nx_s;
  logic [15:0]             ts_r, ts_nx_s;
  logic                    err_r, err_nx_s;
  logic [15:0]             expected_r;
  logic                    seq_valid_r;
  logic                    fin_s, drop_fin_s;
  logic                    hdr_match_s, pat_bad_s, len_bad_s;
  logic                    seq_ok_s, ok_s;
  logic [15:0]             lat_s;
  logic [DATA_WIDTH-1:0]   exp_byte_s;

  assign eth.s_eth_hdr_ready           = (state_r == ST_IDLE);
  assign eth.s_eth_payload_axis_tready = (state_r == ST_PAYLOAD) || (state_r == ST_DROP) ||
                                         (state_r == ST_DROP_LONG);

  assign hdr_match_s = (eth.s_eth_dest_mac == local_mac) && (eth.s_eth_src_mac == peer_mac) &&
                       (eth.s_eth_type == ETH_TYPE);

  // Next-state and per-beat capture/check logic.
  always_comb begin
    state_nx_s    = state_r;
    byte_cnt_nx_s = byte_cnt_r;
    idx_nx_s      = idx_r;
    ts_nx_s       = ts_r;
    err_nx_s      = err_r;
    fin_s         = 1'b0;
    drop_fin_s    = 1'b0;
    exp_byte_s    = byte_cnt_r[7:0] + idx_r[7:0];
    pat_bad_s     = (byte_cnt_r >= 16'd4) && (eth.s_eth_payload_axis_tdata != exp_byte_s);
    len_bad_s     = eth.s_eth_payload_axis_tlast ?
                    ((byte_cnt_r != LAST_IDX) || eth.s_eth_payload_axis_tuser) :
                    (byte_cnt_r == LAST_IDX);
    case (state_r)
      ST_IDLE: begin
        if (eth.s_eth_hdr_valid) begin
          byte_cnt_nx_s = 16'd0;
          idx_nx_s      = 16'd0;
          ts_nx_s       = 16'd0;
          err_nx_s      = 1'b0;
          state_nx_s    = hdr_match_s ? ST_PAYLOAD : ST_DROP;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (eth.s_eth_payload_axis_tvalid) begin
          byte_cnt_nx_s = byte_cnt_r + 16'd1;
          err_nx_s      = err_r | pat_bad_s | len_bad_s;
          case (byte_cnt_r)
            16'd0:   idx_nx_s[15:8] = eth.s_eth_payload_axis_tdata;
            16'd1:   idx_nx_s[7:0]  = eth.s_eth_payload_axis_tdata;
            16'd2:   ts_nx_s[15:8]  = eth.s_eth_payload_axis_tdata;
            16'd3:   ts_nx_s[7:0]   = eth.s_eth_payload_axis_tdata;
            default: idx_nx_s       = idx_r;
          endcase
          if (eth.s_eth_payload_axis_tlast) begin
            fin_s      = 1'b1;
            state_nx_s = ST_REPORT;
          end else if (byte_cnt_r == LAST_IDX) begin
            state_nx_s = ST_DROP_LONG;
          end else begin
            state_nx_s = ST_PAYLOAD;
          end
        end else begin
          state_nx_s = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (eth.s_eth_payload_axis_tvalid && eth.s_eth_payload_axis_tlast) begin
          drop_fin_s = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DROP;
        end
      end
      ST_DROP_LONG: begin
        if (eth.s_eth_payload_axis_tvalid && eth.s_eth_payload_axis_tlast) begin
          fin_s      = 1'b1;
          state_nx_s = ST_REPORT;
        end else begin
          state_nx_s = ST_DROP_LONG;
        end
      end
      ST_REPORT: state_nx_s = ST_IDLE;
      default:   state_nx_s = ST_IDLE;
    endcase
  end

  // The result is registered on the closing beat so it is visible exactly during REPORT.
  assign seq_ok_s = !seq_valid_r || (idx_nx_s == expected_r);
  assign ok_s     = !err_nx_s && seq_ok_s;
  assign lat_s    = timestamp - ts_nx_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Frame context, results and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_r     <= 16'd0;
      idx_r          <= 16'd0;
      ts_r           <= 16'd0;
      err_r          <= 1'b0;
      expected_r     <= 16'd0;
      seq_valid_r    <= 1'b0;
      result_valid   <= 1'b0;
      result_ok      <= 1'b0;
      result_index   <= 16'd0;
      result_latency <= 16'd0;
      good_count     <= 32'd0;
      hdr_err_count  <= 32'd0;
      seq_err_count  <= 32'd0;
      data_err_count <= 32'd0;
      max_latency    <= 16'd0;
    end else begin
      byte_cnt_r   <= byte_cnt_nx_s;
      idx_r        <= idx_nx_s;
      ts_r         <= ts_nx_s;
      err_r        <= err_nx_s;
      result_valid <= fin_s;
      if (fin_s) begin
        result_ok      <= ok_s;
        result_index   <= idx_nx_s;
        result_latency <= lat_s;
        expected_r     <= idx_nx_s + 16'd1;
        seq_valid_r    <= 1'b1;
        if (!seq_ok_s) seq_err_count <= sat_inc(seq_err_count);
        if (err_nx_s) data_err_count <= sat_inc(data_err_count);
        if (ok_s) begin
          good_count <= sat_inc(good_count);
          if (lat_s > max_latency) max_latency <= lat_s;
        end
      end
      if (drop_fin_s) hdr_err_count <= sat_inc(hdr_err_count);
    end
  end

endmodule
